// File: rtl/flip_seq_pkg.sv
`default_nettype none
// ============================================================================
// flip_seq_pkg : shared state encoding and field widths for flip_sequencer
// Revision 1.0
// ============================================================================
package flip_seq_pkg;

  localparam int IDX_W  = 16;
  localparam int REPS_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BASE    = 2'd1,
    FLIPPED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/flip_phase_timer.sv
`default_nettype none
// ============================================================================
// flip_phase_timer : loadable down-counter that saturates at zero
// Revision 1.0
// ============================================================================
module flip_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             flip_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge flip_clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/flip_sequencer.sv
`default_nettype none
// ============================================================================
// flip_sequencer : drives a base vector, periodically toggling one bit
// Revision 1.0
// ============================================================================
module flip_sequencer
  import flip_seq_pkg::*;
#(
  parameter int NUM_INS = 8,
  parameter int CNT_W   = 32
) (
  input  logic               flip_clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [NUM_INS-1:0] cfg_base,
  input  logic [IDX_W-1:0]   cfg_index,
  input  logic [CNT_W-1:0]   cfg_half_period,
  input  logic [REPS_W-1:0]  cfg_reps,
  input  logic               abort,
  output logic [NUM_INS-1:0] dut_inputs,
  output logic               trigger,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [IDX_W:0] c_num_ins = NUM_INS[IDX_W:0];

  state_t              r_state;
  logic [NUM_INS-1:0]  r_base;
  logic [IDX_W-1:0]    r_index;
  logic [CNT_W-1:0]    r_half;
  logic [REPS_W-1:0]   r_remaining;

  logic                w_accept;
  logic                w_cfg_bad;
  logic                w_start;
  logic                w_expired;
  logic                w_phase_end;
  logic                w_last;
  logic                w_load;
  logic [CNT_W-1:0]    w_load_val;
  logic [NUM_INS-1:0]  w_flip_mask;

  assign cfg_ready   = (r_state == IDLE) && !abort;
  assign w_accept    = cfg_valid && cfg_ready;
  assign w_cfg_bad   = ({1'b0, cfg_index} >= c_num_ins) || (cfg_half_period == '0);
  assign w_start     = w_accept && !w_cfg_bad;
  assign w_phase_end = (r_state != IDLE) && !abort && w_expired;
  // remaining == 0 while active means continuous mode, so only 1 ends the run
  assign w_last      = (r_state == FLIPPED) && (r_remaining == REPS_W'(1));
  assign w_load      = w_start || (w_phase_end && !w_last);
  assign w_load_val  = w_start ? (cfg_half_period - CNT_W'(1)) : (r_half - CNT_W'(1));
  assign w_flip_mask = NUM_INS'(1) << r_index;

  flip_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .flip_clk (flip_clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  always_ff @(posedge flip_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_index     <= '0;
      r_half      <= '0;
      r_remaining <= '0;
      dut_inputs  <= '0;
      trigger     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      trigger <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_cfg_bad) begin
            cfg_err <= 1'b1;
          end else if (w_start) begin
            r_state     <= BASE;
            r_base      <= cfg_base;
            r_index     <= cfg_index;
            r_half      <= cfg_half_period;
            r_remaining <= cfg_reps;
            dut_inputs  <= cfg_base;
            busy        <= 1'b1;
          end
        end
        BASE: begin
          if (abort) begin
            r_state    <= IDLE;
            dut_inputs <= r_base;
            busy       <= 1'b0;
          end else if (w_expired) begin
            r_state    <= FLIPPED;
            dut_inputs <= r_base ^ w_flip_mask;
            trigger    <= 1'b1;
          end
        end
        FLIPPED: begin
          if (abort) begin
            r_state    <= IDLE;
            dut_inputs <= r_base;
            busy       <= 1'b0;
          end else if (w_expired) begin
            dut_inputs <= r_base;
            if (w_last) begin
              r_state     <= IDLE;
              r_remaining <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else begin
              r_state <= BASE;
              if (r_remaining != '0) begin
                r_remaining <= r_remaining - REPS_W'(1);
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flip_sequencer.sv
`default_nettype none
// ============================================================================
// tb_flip_sequencer : randomized scoreboard bench against a cycle-count model
// Revision 1.0
// ============================================================================
module tb_flip_sequencer;

  localparam int N  = 8;
  localparam int CW = 32;

  logic          flip_clk = 1'b0;
  logic          reset    = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [N-1:0]  cfg_base = '0;
  logic [15:0]   cfg_index = '0;
  logic [CW-1:0] cfg_half_period = '0;
  logic [15:0]   cfg_reps = '0;
  logic          abort = 1'b0;
  logic [N-1:0]  dut_inputs;
  logic          trigger;
  logic          busy;
  logic          done;
  logic          cfg_err;

  flip_sequencer #(
    .NUM_INS (N),
    .CNT_W   (CW)
  ) dut (
    .flip_clk        (flip_clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_base        (cfg_base),
    .cfg_index       (cfg_index),
    .cfg_half_period (cfg_half_period),
    .cfg_reps        (cfg_reps),
    .abort           (abort),
    .dut_inputs      (dut_inputs),
    .trigger         (trigger),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
  );

  always #5 flip_clk = ~flip_clk;

  typedef struct packed {
    logic [N-1:0] dut;
    logic         trig;
    logic         busy;
    logic         done;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position in the run is a plain cycle count since acceptance
  bit           m_active = 1'b0;
  logic [N-1:0] m_base = '0;
  logic [N-1:0] m_dut  = '0;
  int           m_index = 0;
  int           m_half  = 0;
  int           m_reps  = 0;
  int           m_k     = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Predict outputs after the coming edge from the inputs now applied, then push them
  task automatic step();
    exp_t e;
    int   kk;
    e = '{dut: m_dut, trig: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
    if (!m_active) begin
      if (cfg_valid && !abort) begin
        if (int'(cfg_index) >= N || cfg_half_period == 0) begin
          e.err = 1'b1;
        end else begin
          m_active = 1'b1;
          m_k      = 0;
          m_base   = cfg_base;
          m_index  = int'(cfg_index);
          m_half   = int'(cfg_half_period);
          m_reps   = int'(cfg_reps);
          m_dut    = cfg_base;
        end
      end
    end else if (abort) begin
      m_active = 1'b0;
      m_dut    = m_base;
    end else begin
      m_k++;
      if (m_reps != 0 && m_k == 2 * m_half * m_reps) begin
        m_active = 1'b0;
        m_dut    = m_base;
        e.done   = 1'b1;
      end else begin
        kk     = m_k % (2 * m_half);
        m_dut  = (kk >= m_half) ? (m_base ^ (N'(1) << m_index)) : m_base;
        e.trig = (kk == m_half);
      end
    end
    e.dut  = m_dut;
    e.busy = m_active;
    @(posedge flip_clk);
    #1;
    exp_q.push_back(e);
  endtask

  always @(negedge flip_clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{dut: dut_inputs, trig: trigger, busy: busy, done: done, err: cfg_err};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: actual dut=%h trig=%b busy=%b done=%b err=%b required dut=%h trig=%b busy=%b done=%b err=%b",
                 $time, a.dut, a.trig, a.busy, a.done, a.err, e.dut, e.trig, e.busy, e.done, e.err);
      end
    end
  end

  task automatic do_reset();
    @(negedge flip_clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_dut_inputs", 32'(dut_inputs), 32'd0);
    check("rst_trigger",    32'(trigger),    32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_cfg_err",    32'(cfg_err),    32'd0);
    m_active  = 1'b0;
    m_dut     = '0;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    @(posedge flip_clk);
    #1;
    @(negedge flip_clk);
    reset = 1'b1;
  endtask

  task automatic run_cfg(logic [N-1:0] b, int idx, int half, int reps, int ncyc,
                         int abort_div, bit rnd_valid, bit end_abort);
    cfg_base        = b;
    cfg_index       = 16'(idx);
    cfg_half_period = CW'(half);
    cfg_reps        = 16'(reps);
    cfg_valid       = 1'b1;
    abort           = 1'b0;
    step();
    cfg_valid = 1'b0;
    repeat (ncyc) begin
      abort     = (abort_div != 0) && ($urandom_range(abort_div - 1) == 0);
      cfg_valid = rnd_valid && ($urandom_range(3) == 0);
      step();
    end
    cfg_valid = 1'b0;
    if (end_abort) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
    end else begin
      abort = 1'b0;
    end
  endtask

  initial begin
    do_reset();
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);

    // Directed: two full flip cycles, then quiet idle
    run_cfg(8'hA5, 3, 4, 2, 20, 0, 1'b0, 1'b1);
    // Out-of-range index and zero half-period are rejected
    run_cfg(8'h3C, 8, 4, 1, 3, 0, 1'b0, 1'b1);
    run_cfg(8'h5A, 2, 0, 1, 3, 0, 1'b0, 1'b1);
    // Continuous single-cycle toggling, stopped by abort
    run_cfg(8'h00, 7, 1, 0, 9, 0, 1'b0, 1'b1);

    // abort beats cfg_valid in IDLE
    cfg_base = 8'hFF; cfg_index = 16'd1; cfg_half_period = CW'(2); cfg_reps = 16'd1;
    cfg_valid = 1'b1;
    abort     = 1'b1;
    #1;
    check("cfg_ready_abort", 32'(cfg_ready), 32'd0);
    step();
    step();
    cfg_valid = 1'b0;
    abort     = 1'b0;
    step();

    // Reset in the middle of FLIPPED, then a fresh run
    run_cfg(8'h0F, 5, 3, 0, 4, 0, 1'b0, 1'b0);
    do_reset();
    run_cfg(8'h81, 0, 2, 1, 6, 0, 1'b0, 1'b1);

    for (int i = 0; i < 25; i++) begin
      run_cfg(N'($urandom), int'($urandom_range(9)), int'($urandom_range(5)),
              int'($urandom_range(3)), int'($urandom_range(30, 1)), 20, 1'b1, 1'b1);
    end

    @(negedge flip_clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flip_sequencer.md
FLIP_SEQUENCER -- requirements
Module: flip_sequencer

Interface
REQ-001 Parameter: NUM_INS, 8, width of the DUT input vector (2..65535).
REQ-002 Parameter: CNT_W, 32, width of the phase timer.
REQ-003 Port: flip_clk input 1; sole clock; all state updates on rising edge.
REQ-004 Port: reset input 1; asynchronous, active-low.
REQ-005 Port: cfg_valid input 1; a configuration word is presented.
REQ-006 Port: cfg_ready output 1; the block accepts configuration; cfg_ready = (state==IDLE) && !abort.
REQ-007 Port: cfg_base input NUM_INS; base input vector.
REQ-008 Port: cfg_index input 16; bit position to toggle.
REQ-009 Port: cfg_half_period input CNT_W; cycles spent in each phase.
REQ-010 Port: cfg_reps input 16; number of flip cycles; 0 = continuous.
REQ-011 Port: abort input 1; synchronous stop request.
REQ-012 Port: dut_inputs output NUM_INS; registered drive to the DUT.
REQ-013 Port: trigger output 1; registered scope trigger.
REQ-014 Port: busy output 1; high in BASE or FLIPPED.
REQ-015 Port: done output 1; one-cycle pulse on normal completion.
REQ-016 Port: cfg_err output 1; one-cycle pulse when a configuration is rejected.

Function
REQ-017 States SHALL be IDLE, BASE and FLIPPED.
REQ-018 Acceptance SHALL occur on cfg_valid && cfg_ready; all cfg_* fields are latched at that edge.
REQ-019 If cfg_index >= NUM_INS or cfg_half_period == 0, the block SHALL pulse cfg_err on the next cycle, stay in IDLE and leave dut_inputs unchanged.
REQ-020 On a valid acceptance, on the next cycle: state = BASE, dut_inputs = cfg_base, busy = 1, remaining reps = cfg_reps.
REQ-021 BASE and FLIPPED SHALL each last exactly cfg_half_period cycles, as counted by the phase timer.
REQ-022 At the BASE-to-FLIPPED transition, dut_inputs SHALL equal base with bit cfg_index inverted.
REQ-023 trigger SHALL be high only during the first FLIPPED cycle, aligned with the change on dut_inputs.
REQ-024 At the end of FLIPPED with cfg_reps == 0, the block SHALL return to BASE and restore base; repetition continues indefinitely.
REQ-025 At the end of FLIPPED with remaining == 1, the block SHALL go to IDLE, restore base, pulse done and drop busy.
REQ-026 At the end of FLIPPED with remaining > 1, the block SHALL decrement remaining and go to BASE.
REQ-027 abort in BASE or FLIPPED SHALL cause, next cycle: IDLE, dut_inputs = base, busy = 0, done = 0, trigger = 0.
REQ-028 abort together with cfg_valid in IDLE: abort wins and the configuration is not accepted.
REQ-029 abort together with a phase end: abort wins.
REQ-030 The phase timer SHALL load cfg_half_period-1 on each phase entry and count down to 0; no wrap-around is reachable.
REQ-031 In IDLE, dut_inputs SHALL hold its last value.

Reset
REQ-032 Assertion of reset SHALL immediately force: state IDLE, dut_inputs 0, trigger 0, busy 0, done 0, cfg_err 0, timer 0, remaining 0.
REQ-033 Reset asserted mid-operation SHALL abandon the sequence with no done pulse.
REQ-034 The first acceptance after release SHALL be possible on the first clock edge after deassertion.

Structure
REQ-035 Package flip_seq_pkg SHALL hold the state enum (IDLE, BASE, FLIPPED) and the constants IDX_W = 16 and REPS_W = 16.
REQ-036 The phase timer SHALL be sub-module flip_phase_timer, with ports load, load_val[CNT_W], expired; reset asynchronous, active-low.
REQ-037 All outputs except cfg_ready SHALL be registered.

Verification
REQ-038 Base 8'hA5, index 3, half 4, reps 2: dut_inputs 0xA5 for 4 cycles, 0xAD for 4 cycles, repeated once more; then 0xA5, one-cycle done, exactly two trigger pulses 8 cycles apart.
REQ-039 Index 8 with NUM_INS 8: one-cycle cfg_err, state IDLE, dut_inputs unchanged, busy 0.
REQ-040 Half 1, reps 0: dut_inputs alternates every cycle and trigger pulses every 2 cycles; abort gives base next cycle and no done.
REQ-041 abort and cfg_valid asserted in the same IDLE cycle: no acceptance, busy stays 0.
REQ-042 Reset asserted mid-FLIPPED: all outputs 0 immediately; a fresh configuration after release runs normally.
